lcb_mem_scheduler: RTL and testbench
====================================

LCB_MEM_SCHEDULER -- requirements
Module: lcb_mem_scheduler

Interface
REQ-001 SHALL have ports: clk input 1 (12.582912 MHz system clock); reset input 1 (asynchronous, active-low); iSwitch input 1 (bank-select level from the frame generator).
REQ-002 SHALL have ports: iMCM_rq input 1; iMCM_data input 12; oMCM_ack output 1.
REQ-003 SHALL have ports: iLCB_rq input 4 (bit n-1 = LCBn); iLCB_data input 48 (LCBn word in bits 12n-1..12n-12); oLCB_ack output 4.
REQ-004 SHALL have ports: oWrEn output 1; oWrAddr output 10; oWrData output 12; oWrBank output 1.
REQ-005 SHALL have ports: oOvf output 5 (bit 4 = MCM, bits 3..0 = LCB4..LCB1, sticky overflow); oBankStart output 1 (one-cycle pulse on bank change).
REQ-006 Parameters: MCM_BASE default 0, MCM_SIZE default 128, LCB_BASE default 128, LCB_SIZE default 224 (LCBn region = LCB_BASE + (n-1)*LCB_SIZE, size LCB_SIZE words).

Function
REQ-007 Source handshake: requester holds rq high with data stable until it sees its ack; ack is a single-cycle pulse; requester drops rq on the edge after ack.
REQ-008 FSM states IDLE, WRITE, ACK; IDLE->WRITE when any rq high at the clock edge; WRITE->ACK unconditionally; ACK->IDLE unconditionally.
REQ-009 Transfer latency: rq sampled high at edge k -> oWrEn high for cycle k+1..k+2 -> ack high for cycle k+2..k+3; 3 clocks per word; no back-to-back grants within a transfer.
REQ-010 Arbitration at IDLE exit: MCM has absolute priority; among LCB requesters, round-robin starting from the LCB after the last LCB granted; after reset, LCB1 first.
REQ-011 Grant, data, bank and address are latched on the IDLE->WRITE edge; changes on inputs during WRITE/ACK have no effect on the transfer.
REQ-012 Each source has a write counter (8 bits); oWrAddr = region base + counter value; oWrData = granted source data; counter increments by 1 on the WRITE->ACK edge when the write was performed.
REQ-013 Region full (counter == region size): WRITE state keeps oWrEn low, counter holds, ack is still issued, matching oOvf bit set and held.
REQ-014 oWrEn, oWrAddr, oWrData, oWrBank are registered; oWrAddr/oWrData valid whenever oWrEn high; outside WRITE oWrEn low and addr/data hold last value.
REQ-015 Bank change: iSwitch registered once; edge (either polarity) detected when registered value differs from its delayed copy; on that cycle oBankStart pulses high one cycle.
REQ-016 On bank-change edge: all five counters cleared to 0, oOvf cleared to 0, oWrBank <= inverted new iSwitch (always writes the bank not being read).
REQ-017 Bank change during WRITE/ACK: in-flight transfer completes with its latched bank and address; counter clear wins over the coincident increment.
REQ-018 Bank change coincident with overflow set: clear wins; oOvf reads 0 afterwards.
REQ-019 Simultaneous rq from all five sources: MCM served first, then LCBs in round-robin order; no source starved beyond 4 LCB transfers while MCM is idle.

Reset
REQ-020 On reset low: FSM IDLE, all counters 0, round-robin pointer at LCB1, oWrEn 0, oWrAddr 0, oWrData 0, oWrBank 1, oMCM_ack 0, oLCB_ack 0, oOvf 0, oBankStart 0, iSwitch registers 0.
REQ-021 Reset asserted mid-transfer aborts it: no ack issued, counter not incremented, no write after release until a new request.

Verification
REQ-022 Single MCM word 0xABC after reset -> oWrEn one cycle with oWrAddr 0, oWrData 0xABC, oWrBank 1; oMCM_ack one cycle later; second word -> address 1.
REQ-023 LCB1..LCB4 and MCM all requesting continuously -> grant order MCM,MCM,... while MCM held; with MCM low, order LCB1,LCB2,LCB3,LCB4,LCB1; first LCB3 address 576.
REQ-024 225 LCB2 words without bank change -> addresses 352..575 written, 225th acked with oWrEn low, oOvf = 5'b00010.
REQ-025 iSwitch toggles 0->1 -> oBankStart pulse two clocks later, oWrBank 0, oOvf 0, next LCB1 write to address 128.
REQ-026 iSwitch toggles while in WRITE state -> that write keeps old bank and address, ack issued, next write of that source at region base.
REQ-027 Reset pulsed during ACK-pending WRITE -> no ack, all outputs at reset values, next MCM write at address 0.

Source files
------------

// File: rtl/lcb_mem_scheduler.sv
// Write scheduler for the LCB capture RAM: arbitrates the MCM and four LCB sources into
// per-source regions of the bank currently not being read, swapping banks on iSwitch edges.
module lcb_mem_scheduler #(
  parameter int unsigned MCM_BASE = 0,
  parameter int unsigned MCM_SIZE = 128,
  parameter int unsigned LCB_BASE = 128,
  parameter int unsigned LCB_SIZE = 224
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic        iMCM_rq,
  input  logic [11:0] iMCM_data,
  output logic        oMCM_ack,
  input  logic [3:0]  iLCB_rq,
  input  logic [47:0] iLCB_data,
  output logic [3:0]  oLCB_ack,
  output logic        oWrEn,
  output logic [9:0]  oWrAddr,
  output logic [11:0] oWrData,
  output logic        oWrBank,
  output logic [4:0]  oOvf,
  output logic        oBankStart
);

  localparam int unsigned DW   = 12;
  localparam int unsigned AW   = 10;
  localparam int unsigned CW   = 8;
  localparam int unsigned CW1  = CW + 1;
  localparam int unsigned NLCB = 4;
  localparam int unsigned NSRC = 5;
  localparam int unsigned SW   = 3;
  localparam logic [SW-1:0] SRC_MCM = SW'(4);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           gnt_q, gnt_d;
  logic [1:0]              rr_q, rr_d;
  logic [NSRC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0]         ovf_q, ovf_d;
  logic                    sw_q, sw_d;
  logic                    sw_dly_q, sw_dly_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DW-1:0]           wr_data_q, wr_data_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    mcm_ack_q, mcm_ack_d;
  logic [NLCB-1:0]         lcb_ack_q, lcb_ack_d;
  logic                    bank_start_q, bank_start_d;

  logic                    bank_edge_c;
  logic [SW-1:0]           pick_c;
  logic [1:0]              rr_idx_c;
  logic                    rr_hit_c;
  logic [DW-1:0]           pick_data_c;
  logic [CW-1:0]           pick_cnt_c;
  logic                    pick_full_c;

  function automatic logic [AW-1:0] src_base(input logic [SW-1:0] s);
    if (s == SRC_MCM) return AW'(MCM_BASE);
    return AW'(LCB_BASE + 32'(s) * LCB_SIZE);
  endfunction

  function automatic logic [CW1-1:0] src_size(input logic [SW-1:0] s);
    if (s == SRC_MCM) return CW1'(MCM_SIZE);
    return CW1'(LCB_SIZE);
  endfunction

  assign bank_edge_c = sw_q ^ sw_dly_q;

  // Arbiter: MCM wins outright, otherwise first LCB requester at or after the RR pointer.
  // A bank edge on the grant edge means the write lands in the freshly cleared region.
  always_comb begin
    pick_c   = SRC_MCM;
    rr_idx_c = '0;
    rr_hit_c = 1'b0;
    for (int i = 0; i < int'(NLCB); i++) begin
      rr_idx_c = rr_q + 2'(i);
      if (!rr_hit_c && iLCB_rq[rr_idx_c]) begin
        pick_c   = {1'b0, rr_idx_c};
        rr_hit_c = 1'b1;
      end
    end
    if (iMCM_rq) pick_c = SRC_MCM;
    pick_data_c = (pick_c == SRC_MCM) ? iMCM_data : iLCB_data[DW*pick_c[1:0] +: DW];
    pick_cnt_c  = bank_edge_c ? '0 : cnt_q[pick_c];
    pick_full_c = {1'b0, pick_cnt_c} >= src_size(pick_c);
  end

  // Transfer FSM and bookkeeping; the bank-edge clear is applied last so it beats increments.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    sw_d         = iSwitch;
    sw_dly_d     = sw_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    mcm_ack_d    = 1'b0;
    lcb_ack_d    = '0;
    bank_start_d = bank_edge_c;

    if (bank_edge_c) wr_bank_d = ~sw_q;

    case (state_q)
      IDLE: begin
        if (iMCM_rq || (|iLCB_rq)) begin
          state_d = WRITE;
          gnt_d   = pick_c;
          if (pick_c != SRC_MCM) rr_d = pick_c[1:0] + 2'd1;
          if (!pick_full_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = src_base(pick_c) + AW'(pick_cnt_c);
            wr_data_d = pick_data_c;
          end
        end
      end
      WRITE: begin
        state_d = ACK;
        if (gnt_q == SRC_MCM) mcm_ack_d = 1'b1;
        else                  lcb_ack_d[gnt_q[1:0]] = 1'b1;
        if (wr_en_q) cnt_d[gnt_q] = cnt_q[gnt_q] + CW'(1);
        else         ovf_d[gnt_q] = 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bank_edge_c) begin
      cnt_d = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      ovf_q        <= '0;
      sw_q         <= 1'b0;
      sw_dly_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_bank_q    <= 1'b1;
      mcm_ack_q    <= 1'b0;
      lcb_ack_q    <= '0;
      bank_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      sw_q         <= sw_d;
      sw_dly_q     <= sw_dly_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
      mcm_ack_q    <= mcm_ack_d;
      lcb_ack_q    <= lcb_ack_d;
      bank_start_q <= bank_start_d;
    end
  end

  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oWrBank    = wr_bank_q;
  assign oMCM_ack   = mcm_ack_q;
  assign oLCB_ack   = lcb_ack_q;
  assign oOvf       = ovf_q;
  assign oBankStart = bank_start_q;

endmodule

// File: tb/tb_lcb_mem_scheduler.sv
// Scoreboard bench for lcb_mem_scheduler: a transaction-level model predicts grant order,
// addresses, banks and overflow; a monitor pops expectations on every ack.
module tb_lcb_mem_scheduler;
  logic        clk = 1'b0;
  logic        reset, iSwitch, iMCM_rq, oMCM_ack;
  logic [11:0] iMCM_data;
  logic [3:0]  iLCB_rq, oLCB_ack;
  logic [47:0] iLCB_data;
  logic        oWrEn, oWrBank, oBankStart;
  logic [9:0]  oWrAddr;
  logic [11:0] oWrData;
  logic [4:0]  oOvf;

  lcb_mem_scheduler dut (
    .clk(clk), .reset(reset), .iSwitch(iSwitch),
    .iMCM_rq(iMCM_rq), .iMCM_data(iMCM_data), .oMCM_ack(oMCM_ack),
    .iLCB_rq(iLCB_rq), .iLCB_data(iLCB_data), .oLCB_ack(oLCB_ack),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrBank(oWrBank),
    .oOvf(oOvf), .oBankStart(oBankStart)
  );

  always #40 clk = ~clk;

  typedef struct { int src; bit wr; int addr; int data; bit bank; } exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0, cyc = 0;
  int m_cnt[5];
  bit [4:0] m_ovf;
  int m_rr;
  bit m_bank;
  int bs_exp = 0, bs_seen = 0;
  int rem[5];
  logic [11:0] wd[5][3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int rbase(int s); return (s == 4) ? 0 : 128 + 224 * s; endfunction
  function automatic int rsize(int s); return (s == 4) ? 128 : 224; endfunction

  task automatic model_reset();
    for (int s = 0; s < 5; s++) m_cnt[s] = 0;
    m_ovf = '0; m_rr = 0; m_bank = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_clear(input bit new_sw);
    for (int s = 0; s < 5; s++) m_cnt[s] = 0;
    m_ovf = '0; m_bank = ~new_sw; bs_exp++;
  endtask

  task automatic push_exp(input int s, input int j);
    exp_t e;
    e.src = s; e.data = int'(wd[s][j]); e.bank = m_bank;
    if (m_cnt[s] >= rsize(s)) begin e.wr = 1'b0; e.addr = 0; m_ovf[s] = 1'b1; end
    else begin e.wr = 1'b1; e.addr = rbase(s) + m_cnt[s]; m_cnt[s]++; end
    exp_q.push_back(e);
  endtask

  // Monitor: capture the write, then check it against the expectation popped on the ack
  bit seen_wr = 0, prev_en = 0, w_bank;
  int w_addr, w_data, w_cyc, mon_src;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      seen_wr = 0; prev_en = 0;
    end else begin
      if (oBankStart) bs_seen++;
      if (oWrEn) begin
        chk("wren_one_cycle", prev_en, 0);
        seen_wr = 1; w_addr = oWrAddr; w_data = oWrData; w_bank = oWrBank; w_cyc = cyc;
      end
      prev_en = oWrEn;
      if (oMCM_ack || oLCB_ack != 4'b0) begin
        chk("ack_onehot", $countones({oMCM_ack, oLCB_ack}), 1);
        mon_src = oMCM_ack ? 4 : oLCB_ack[0] ? 0 : oLCB_ack[1] ? 1 : oLCB_ack[2] ? 2 : 3;
        if (exp_q.size() == 0) chk("unexpected_ack_src", mon_src, -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("grant_src", mon_src, mon_e.src);
          chk("write_performed", seen_wr, mon_e.wr);
          if (seen_wr && mon_e.wr) begin
            chk("wr_addr", w_addr, mon_e.addr);
            chk("wr_data", w_data, mon_e.data);
            chk("wr_bank", w_bank, mon_e.bank);
            chk("ack_after_write", cyc - w_cyc, 1);
          end
        end
        seen_wr = 0;
      end
    end
  end

  task automatic set_rem(input int l1, input int l2, input int l3, input int l4, input int m);
    rem[0] = l1; rem[1] = l2; rem[2] = l3; rem[3] = l4; rem[4] = m;
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 3; j++) wd[s][j] = 12'($urandom);
  endtask

  // One burst: model the whole grant sequence, then play the requester handshake
  task automatic round(input bit tog);
    int left[5], sent[5], c, t0, busy;
    bit tog_pend, new_sw, any, found;
    logic [4:0] acks;
    tog_pend = tog; new_sw = ~iSwitch; any = 0;
    for (int s = 0; s < 5; s++) begin left[s] = rem[s]; sent[s] = 0; if (rem[s] > 0) any = 1; end
    while (left[4] > 0) begin
      push_exp(4, rem[4] - left[4]); left[4]--;
      if (tog_pend) begin model_clear(new_sw); tog_pend = 0; end
    end
    forever begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (!found && left[c] > 0) begin
          push_exp(c, rem[c] - left[c]); left[c]--; m_rr = (c + 1) % 4; found = 1;
          if (tog_pend) begin model_clear(new_sw); tog_pend = 0; end
        end
      end
      if (!found) break;
    end

    @(negedge clk);
    iMCM_rq = (rem[4] > 0); iMCM_data = wd[4][0];
    for (int s = 0; s < 4; s++) begin iLCB_rq[s] = (rem[s] > 0); iLCB_data[s*12 +: 12] = wd[s][0]; end
    if (tog && any) iSwitch = new_sw;
    t0 = cyc; busy = any;
    for (int n = 0; n < 300 && busy != 0; n++) begin
      @(negedge clk);
      acks = {oMCM_ack, oLCB_ack};
      for (int s = 0; s < 5; s++) if (acks[s]) begin
        if (t0 >= 0) begin chk("first_ack_latency", cyc - t0, 2); t0 = -1; end
        sent[s]++;
        if (sent[s] < rem[s]) begin
          if (s == 4) iMCM_data = wd[4][sent[s]]; else iLCB_data[s*12 +: 12] = wd[s][sent[s]];
        end else begin
          if (s == 4) iMCM_rq = 1'b0; else iLCB_rq[s] = 1'b0;
        end
      end
      busy = (iMCM_rq || iLCB_rq != 4'b0) ? 1 : 0;
    end
    chk("round_complete", busy, 0);
    iMCM_rq = 1'b0; iLCB_rq = 4'b0;
    repeat (2) @(negedge clk);
    chk("ovf", oOvf, m_ovf);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("bank_idle", oWrBank, m_bank);
    chk("bank_start_count", bs_seen, bs_exp);
    exp_q.delete();
  endtask

  task automatic toggle_idle();
    @(negedge clk); iSwitch = ~iSwitch;
    @(negedge clk); chk("bank_start_early", oBankStart, 0);
    @(negedge clk); chk("bank_start_pulse", oBankStart, 1);
    model_clear(iSwitch);
    chk("bank_after_switch", oWrBank, m_bank);
    chk("ovf_after_switch", oOvf, 0);
    @(negedge clk); chk("bank_start_end", oBankStart, 0);
    chk("bank_start_count", bs_seen, bs_exp);
  endtask

  task automatic check_reset_vals();
    chk("rst_wren", oWrEn, 0);     chk("rst_addr", oWrAddr, 0);
    chk("rst_data", oWrData, 0);   chk("rst_bank", oWrBank, 1);
    chk("rst_mcm_ack", oMCM_ack, 0); chk("rst_lcb_ack", oLCB_ack, 0);
    chk("rst_ovf", oOvf, 0);       chk("rst_bank_start", oBankStart, 0);
  endtask

  initial begin
    int filled, n;
    reset = 1'b0; iSwitch = 1'b0; iMCM_rq = 1'b0; iMCM_data = '0; iLCB_rq = '0; iLCB_data = '0;
    model_reset();
    #100;
    check_reset_vals();
    @(negedge clk); reset = 1'b1;

    // Two MCM words, first is 0xABC at address 0
    set_rem(0, 0, 0, 0, 2); wd[4][0] = 12'hABC;
    round(1'b0);

    // Everyone requesting: MCM words first, then LCB1..LCB4, LCB1
    set_rem(2, 1, 1, 1, 3);
    round(1'b0);

    toggle_idle();                          // 0->1: bank 0, counters cleared
    for (int i = 0; i < 225; i++) begin set_rem(0, 1, 0, 0, 0); round(1'b0); end
    chk("lcb2_overflow", oOvf, 5'b00010);
    toggle_idle();
    toggle_idle();
    set_rem(1, 0, 0, 0, 0); round(1'b0);    // LCB1 back at 128

    // Switch lands while the first write is in flight
    set_rem(2, 0, 0, 0, 0); round(1'b1);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3) == 0) toggle_idle();
      set_rem($urandom_range(1) * $urandom_range(1, 3), $urandom_range(1) * $urandom_range(1, 3),
              $urandom_range(1) * $urandom_range(1, 3), $urandom_range(1) * $urandom_range(1, 3),
              $urandom_range(1) * $urandom_range(1, 3));
      if (rem[0] + rem[1] + rem[2] + rem[3] + rem[4] == 0) rem[$urandom_range(4)] = 1;
      round($urandom_range(7) == 0);
    end

    // Fill MCM, then overflow coincides with a bank switch: clear must win
    toggle_idle();
    filled = 0;
    while (filled < 128) begin
      n = (128 - filled > 3) ? 3 : 128 - filled;
      set_rem(0, 0, 0, 0, n); round(1'b0); filled += n;
    end
    set_rem(0, 0, 0, 0, 1); round(1'b1);
    chk("ovf_clear_wins", oOvf, 0);

    // Reset in the middle of a write aborts it
    @(negedge clk); iMCM_rq = 1'b1; iMCM_data = 12'h5A5;
    @(negedge clk);
    chk("pre_reset_wren", oWrEn, 1);
    chk("pre_reset_addr", oWrAddr, rbase(4) + m_cnt[4]);
    #5 reset = 1'b0; iMCM_rq = 1'b0; iSwitch = 1'b0;
    #1 check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) begin @(negedge clk); chk("no_write_after_reset", oWrEn, 0); end
    set_rem(0, 0, 0, 0, 1); round(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
